// File: rtl/smg_pkg.sv
// Shared definitions for the 7-segment display path: digit geometry, blank code,
// default saturation limit, conversion FSM encoding and leading-zero blanking helper.
package smg_pkg;

    localparam int DIGIT_W     = 4;
    localparam int NUM_DIGITS  = 4;
    localparam int BCD_W       = DIGIT_W * NUM_DIGITS;
    localparam int MAX_VAL_DEF = 9999;

    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Blanks zero digits from the most significant end; the units digit always shows.
    function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] bcd,
                                                  input logic [DIGIT_W-1:0] code);
        logic [BCD_W-1:0] res;
        logic             lead;
        res  = bcd;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (lead && (bcd[i*DIGIT_W +: DIGIT_W] == '0))
                res[i*DIGIT_W +: DIGIT_W] = code;
            else
                lead = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/smg_bin2bcd_module_bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
// Purely combinational, no handshake.
module bcd_digit_adj
    import smg_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj
);

    assign adj = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/smg_bin2bcd_module.sv
// Sequential binary-to-BCD converter (one bit per clock, Done BIN_W+1 clocks after accept, Start ignored while busy).
// Optional leading-zero blanking of the result when SMG_BLANK_LZ_EN is defined.
module smg_bin2bcd_module
    import smg_pkg::*;
#(
    parameter int               BIN_W   = 14,
    parameter logic [BIN_W-1:0] MAX_VAL = BIN_W'(MAX_VAL_DEF)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [BIN_W-1:0] Bin_Sig,
    input  logic             Start_Sig,
    output logic             Busy_Sig,
    output logic             Done_Sig,
    output logic             Over_Sig,
    output logic [BCD_W-1:0] Number_Sig
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] op;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] number_nxt;
    logic             over_q;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (bcd[g*DIGIT_W +: DIGIT_W]),
            .adj   (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        number_nxt = bcd;
`ifdef SMG_BLANK_LZ_EN
        number_nxt = blank_lz(bcd, BLANK_CODE);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op         <= '0;
            bcd        <= '0;
            over_q     <= 1'b0;
            Busy_Sig   <= 1'b0;
            Done_Sig   <= 1'b0;
            Over_Sig   <= 1'b0;
            Number_Sig <= '0;
        end else begin
            Done_Sig <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start_Sig) begin
                        op       <= (Bin_Sig > MAX_VAL) ? MAX_VAL : Bin_Sig;
                        over_q   <= (Bin_Sig > MAX_VAL);
                        bcd      <= '0;
                        cnt      <= '0;
                        Busy_Sig <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Operand MSB enters the units LSB; digits are corrected before shifting.
                    {bcd, op} <= {bcd_adj[BCD_W-2:0], op, 1'b0};
                    cnt       <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    Number_Sig <= number_nxt;
                    Over_Sig   <= over_q;
                    Done_Sig   <= 1'b1;
                    Busy_Sig   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smg_bin2bcd_module.sv
// Bench for smg_bin2bcd_module: directed vectors, expected results queued at the accept
// edge and checked by a monitor whenever Done_Sig is presented.
module tb_smg_bin2bcd_module;

    logic        CLK = 1'b0;
    logic        RST;
    logic [13:0] Bin_Sig;
    logic        Start_Sig;
    logic        Busy_Sig;
    logic        Done_Sig;
    logic        Over_Sig;
    logic [15:0] Number_Sig;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    int pushed    = 0;
    logic [16:0] sb[$];

    smg_bin2bcd_module dut (
        .CLK        (CLK),
        .RST        (RST),
        .Bin_Sig    (Bin_Sig),
        .Start_Sig  (Start_Sig),
        .Busy_Sig   (Busy_Sig),
        .Done_Sig   (Done_Sig),
        .Over_Sig   (Over_Sig),
        .Number_Sig (Number_Sig)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pick(input logic [15:0] plain, input logic [15:0] blank);
`ifdef SMG_BLANK_LZ_EN
        return blank;
`else
        return plain;
`endif
    endfunction

    task automatic push(input logic [15:0] num, input logic over);
        sb.push_back({over, num});
        pushed++;
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        logic [16:0] e;
        if (!RST && Done_Sig) begin
            done_seen++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: Number=%h Over=%b with no expectation", Number_Sig, Over_Sig);
            end else begin
                e = sb.pop_front();
                check("number", 32'(Number_Sig), 32'(e[15:0]));
                check("over",   32'(Over_Sig),   32'(e[16]));
            end
        end
    end

    // Counts clocks from the current edge until Done is seen (bounded).
    task automatic wait_done(output int k, output logic busy_ok);
        k = 0;
        busy_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            k++;
            if (Done_Sig) break;
            if (!Busy_Sig) busy_ok = 1'b0;
        end
    endtask

    task automatic convert(input logic [13:0] bin, input logic [15:0] plain,
                           input logic [15:0] blank, input logic over);
        int   k;
        logic bok;
        @(negedge CLK);
        Bin_Sig   = bin;
        Start_Sig = 1'b1;
        @(posedge CLK);
        push(pick(plain, blank), over);
        #1;
        Start_Sig = 1'b0;
        Bin_Sig   = ~bin;
        wait_done(k, bok);
        check("latency", 32'(k), 32'd15);
        check("busy_during", 32'(bok), 32'd1);
        check("busy_at_done", 32'(Busy_Sig), 32'd0);
    endtask

    initial begin
        int   k;
        logic bok;
        RST = 1'b1;
        Start_Sig = 1'b0;
        Bin_Sig = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_number", 32'(Number_Sig), 32'h0);
        check("rst_busy",   32'(Busy_Sig),   32'd0);
        check("rst_done",   32'(Done_Sig),   32'd0);
        check("rst_over",   32'(Over_Sig),   32'd0);
        RST = 1'b0;

        // Basic conversion and clamp boundaries
        convert(14'd1234,  16'h1234, 16'h1234, 1'b0);
        convert(14'd0,     16'h0000, 16'hFFF0, 1'b0);
        convert(14'd9999,  16'h9999, 16'h9999, 1'b0);
        convert(14'd10000, 16'h9999, 16'h9999, 1'b1);
        convert(14'd16383, 16'h9999, 16'h9999, 1'b1);
        convert(14'd45,    16'h0045, 16'hFF45, 1'b0);
        convert(14'd1005,  16'h1005, 16'h1005, 1'b0);
        convert(14'd5678,  16'h5678, 16'h5678, 1'b0);

        // Start held high: back-to-back conversions, operand changes mid-run ignored
        @(negedge CLK);
        Bin_Sig = 14'd7;
        Start_Sig = 1'b1;
        @(posedge CLK);
        push(pick(16'h0007, 16'hFFF7), 1'b0);
        #1 Bin_Sig = 14'd8;
        wait_done(k, bok);
        check("b2b_first_latency", 32'(k), 32'd15);
        push(pick(16'h0008, 16'hFFF8), 1'b0);
        @(posedge CLK);
        #1 Bin_Sig = 14'd7;
        wait_done(k, bok);
        check("b2b_second_latency", 32'(k), 32'd15);
        Start_Sig = 1'b0;

        // Start pulse during Busy is ignored
        @(negedge CLK);
        Bin_Sig = 14'd321;
        Start_Sig = 1'b1;
        @(posedge CLK);
        push(pick(16'h0321, 16'hF321), 1'b0);
        #1 Start_Sig = 1'b0;
        repeat (4) @(posedge CLK);
        #1 Bin_Sig = 14'd999;
        Start_Sig = 1'b1;
        @(posedge CLK);
        #1 Start_Sig = 1'b0;
        wait_done(k, bok);
        check("ignored_start_latency", 32'(k), 32'd10);
        repeat (20) @(posedge CLK);

        // Reset in the middle of a conversion discards it
        @(negedge CLK);
        Bin_Sig = 14'd1234;
        Start_Sig = 1'b1;
        @(posedge CLK);
        #1 Start_Sig = 1'b0;
        repeat (6) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_number", 32'(Number_Sig), 32'h0);
        check("midrst_busy",   32'(Busy_Sig),   32'd0);
        check("midrst_done",   32'(Done_Sig),   32'd0);
        RST = 1'b0;
        repeat (20) @(posedge CLK);
        convert(14'd42, 16'h0042, 16'hFF42, 1'b0);

        repeat (5) @(posedge CLK);
        #1;
        check("number_held", 32'(Number_Sig), 32'(pick(16'h0042, 16'hFF42)));
        check("queue_empty", 32'(sb.size()), 32'd0);
        check("done_count",  32'(done_seen), 32'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
